// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit.
//   - condition-code encodings COND_EQZ .. COND_NEVER
//   - 2-bit saturating counter encodings SNT, WNT, WT, ST
//   - CNT_INIT_DEFAULT: the counter value loaded at reset (weakly not-taken)
package branch_pkg;

    localparam logic [2:0] COND_EQZ    = 3'b000;
    localparam logic [2:0] COND_NEZ    = 3'b001;
    localparam logic [2:0] COND_LTZ    = 3'b010;
    localparam logic [2:0] COND_GEZ    = 3'b011;
    localparam logic [2:0] COND_GTZ    = 3'b100;
    localparam logic [2:0] COND_LEZ    = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CNT_INIT_DEFAULT = WNT;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   res_cond  in  3      condition code (see branch_pkg COND_*)
//   res_a     in  WIDTH  operand under test, treated as two's complement
//   taken     out 1      condition outcome
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       res_cond,
    input  logic [WIDTH-1:0] res_a,
    output logic             taken
);

    logic zero;
    logic neg;

    assign zero = ~|res_a;
    assign neg  = res_a[WIDTH-1];

    always_comb begin
        taken = 1'b0;
        case (res_cond)
            COND_EQZ:    taken = zero;
            COND_NEZ:    taken = ~zero;
            COND_LTZ:    taken = neg;
            COND_GEZ:    taken = ~neg;
            COND_GTZ:    taken = ~neg & ~zero;
            COND_LEZ:    taken = neg | zero;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit with a direct-mapped 2-bit saturating predictor.
// Fetch looks up a prediction combinationally; execute resolves a branch,
// trains the predictor, and one cycle later reports the outcome, whether
// it was mispredicted, and the correct next PC.
// Optional feature macro: BRANCH_STATS_EN (resolved / mispredict counters).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   lk_pc      in  PC_W        fetch PC for lookup
//   lk_taken   out 1           prediction (counter MSB), pre-update value
//   res_valid  in  1           a branch resolves this cycle
//   res_pc     in  PC_W        PC of the resolving branch
//   res_cond   in  3           condition code
//   res_a      in  WIDTH       operand under test
//   res_pred   in  1           prediction used at fetch
//   res_target in  PC_W        taken target
//   res_fall   in  PC_W        fall-through PC
//   flush      in  1           kills the resolution this cycle
//   out_valid/out_taken/out_mispred/out_redirect  registered result
//   stat_br, stat_mp out 16    resolved / mispredicted counts (0 if disabled)
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int         WIDTH    = 16,
    parameter int         PC_W     = 16,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = CNT_INIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  lk_pc,
    output logic             lk_taken,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [2:0]       res_cond,
    input  logic [WIDTH-1:0] res_a,
    input  logic             res_pred,
    input  logic [PC_W-1:0]  res_target,
    input  logic [PC_W-1:0]  res_fall,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_taken,
    output logic             out_mispred,
    output logic [PC_W-1:0]  out_redirect,
    output logic [15:0]      stat_br,
    output logic [15:0]      stat_mp
);

    localparam int DEPTH = 2 ** IDX_W;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    logic [1:0]       cnt_q [DEPTH];
    logic [1:0]       cnt_d [DEPTH];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] res_idx;
    logic             actual;
    logic             accept;
    logic             mispred;

    logic             out_valid_q,    out_valid_d;
    logic             out_taken_q,    out_taken_d;
    logic             out_mispred_q,  out_mispred_d;
    logic [PC_W-1:0]  out_redirect_q, out_redirect_d;

    // Bit 0 is always zero (halfword aligned) and high bits are not tagged.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[0], res_pc[0],
                              lk_pc[PC_W-1:IDX_W+1], res_pc[PC_W-1:IDX_W+1]};

    assign lk_idx  = lk_pc[IDX_W:1];
    assign res_idx = res_pc[IDX_W:1];

    branch_cond_eval #(.WIDTH(WIDTH)) u_cond (
        .res_cond (res_cond),
        .res_a    (res_a),
        .taken    (actual)
    );

    assign accept  = res_valid & ~flush;
    assign mispred = accept & (actual != res_pred);

    // Read from the registered table, so a same-cycle update is not seen yet.
    assign lk_taken = cnt_q[lk_idx][1];

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d[res_idx] = actual ? sat_inc(cnt_q[res_idx]) : sat_dec(cnt_q[res_idx]);
        end
    end

    always_comb begin
        out_valid_d    = accept;
        out_mispred_d  = mispred;
        out_taken_d    = out_taken_q;
        out_redirect_d = out_redirect_q;
        if (accept) begin
            out_taken_d    = actual;
            out_redirect_d = actual ? res_target : res_fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
            out_valid_q    <= 1'b0;
            out_taken_q    <= 1'b0;
            out_mispred_q  <= 1'b0;
            out_redirect_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_taken_q    <= out_taken_d;
            out_mispred_q  <= out_mispred_d;
            out_redirect_q <= out_redirect_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_taken    = out_taken_q;
    assign out_mispred  = out_mispred_q;
    assign out_redirect = out_redirect_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_br_q, stat_br_d;
    logic [15:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (accept && stat_br_q != 16'hFFFF) begin
            stat_br_d = stat_br_q + 16'd1;
        end
        if (mispred && stat_mp_q != 16'hFFFF) begin
            stat_mp_d = stat_mp_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_br = stat_br_q;
    assign stat_mp = stat_mp_q;
`else
    assign stat_br = '0;
    assign stat_mp = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed steps plus a random
// run, all compared against a behavioural model of the predictor table.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] lk_pc = '0;
    logic        lk_taken;
    logic        res_valid = 1'b0;
    logic [15:0] res_pc = '0;
    logic [2:0]  res_cond = '0;
    logic [15:0] res_a = '0;
    logic        res_pred = 1'b0;
    logic [15:0] res_target = '0;
    logic [15:0] res_fall = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_taken;
    logic        out_mispred;
    logic [15:0] out_redirect;
    logic [15:0] stat_br;
    logic [15:0] stat_mp;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_cnt [16];
    bit          m_taken;
    logic [15:0] m_redir;
    int          m_br;
    int          m_mp;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_taken(lk_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_cond(res_cond),
        .res_a(res_a), .res_pred(res_pred), .res_target(res_target),
        .res_fall(res_fall), .flush(flush), .out_valid(out_valid),
        .out_taken(out_taken), .out_mispred(out_mispred),
        .out_redirect(out_redirect), .stat_br(stat_br), .stat_mp(stat_mp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Condition outcome from the operand's signed value.
    function automatic bit cond_ref(input logic [2:0] c, input logic [15:0] a);
        int sa;
        sa = int'($signed(a));
        case (c)
            3'd0: return sa == 0;
            3'd1: return sa != 0;
            3'd2: return sa < 0;
            3'd3: return sa >= 0;
            3'd4: return sa > 0;
            3'd5: return sa <= 0;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [15:0] pc);
        return int'(pc[4:1]);
    endfunction

    function automatic bit pred_of(input logic [15:0] pc);
        return m_cnt[idx_of(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        m_taken = 1'b0;
        m_redir = '0;
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
        check({tag, "_stat_br"}, {16'h0, stat_br}, m_br[31:0]);
        check({tag, "_stat_mp"}, {16'h0, stat_mp}, m_mp[31:0]);
`else
        check({tag, "_stat_br"}, {16'h0, stat_br}, 32'h0);
        check({tag, "_stat_mp"}, {16'h0, stat_mp}, 32'h0);
`endif
    endtask

    // Assert reset asynchronously, check immediately, release on a negedge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        res_valid = 1'b0;
        flush = 1'b0;
        #1;
        model_reset();
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_taken"}, {31'h0, out_taken}, 32'h0);
        check({tag, "_mispred"}, {31'h0, out_mispred}, 32'h0);
        check({tag, "_redirect"}, {16'h0, out_redirect}, 32'h0);
        check({tag, "_lk_taken"}, {31'h0, lk_taken}, {31'h0, pred_of(lk_pc)});
        check_stats(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive, check lookup before the edge, check results after.
    task automatic step(input string tag, input bit v, input bit fl,
                        input logic [15:0] pc, input logic [2:0] c,
                        input logic [15:0] a, input bit pred,
                        input logic [15:0] tgt, input logic [15:0] fal,
                        input logic [15:0] lkpc);
        bit act;
        bit acc;
        bit mp;
        res_valid = v; flush = fl; res_pc = pc; res_cond = c; res_a = a;
        res_pred = pred; res_target = tgt; res_fall = fal; lk_pc = lkpc;
        #1;
        check({tag, "_lk_pre"}, {31'h0, lk_taken}, {31'h0, pred_of(lkpc)});
        @(posedge clk);
        #1;
        act = cond_ref(c, a);
        acc = v && !fl;
        mp  = acc && (act != pred);
        if (acc) begin
            m_taken = act;
            m_redir = act ? tgt : fal;
            if (act) m_cnt[idx_of(pc)] = (m_cnt[idx_of(pc)] == 3) ? 3 : m_cnt[idx_of(pc)] + 1;
            else     m_cnt[idx_of(pc)] = (m_cnt[idx_of(pc)] == 0) ? 0 : m_cnt[idx_of(pc)] - 1;
            if (m_br < 65535) m_br++;
            if (mp && m_mp < 65535) m_mp++;
        end
        check({tag, "_valid"}, {31'h0, out_valid}, {31'h0, acc});
        check({tag, "_mispred"}, {31'h0, out_mispred}, {31'h0, mp});
        check({tag, "_taken"}, {31'h0, out_taken}, {31'h0, m_taken});
        check({tag, "_redirect"}, {16'h0, out_redirect}, {16'h0, m_redir});
        check({tag, "_lk_post"}, {31'h0, lk_taken}, {31'h0, pred_of(lkpc)});
        check_stats(tag);
    endtask

    logic [15:0] sweep_a [3];
    logic [15:0] pick_a [5];

    initial begin
        sweep_a[0] = 16'h0000; sweep_a[1] = 16'h0001; sweep_a[2] = 16'h8000;
        pick_a[0] = 16'h0000; pick_a[1] = 16'h0001; pick_a[2] = 16'h8000;
        pick_a[3] = 16'hFFFF; pick_a[4] = 16'h7FFF;
        lk_pc = 16'h0004;

        do_reset("reset");

        // Spot checks of the condition table straight from the definition.
        check("gtz_fn", {31'h0, cond_ref(3'd4, 16'h0001)}, 32'h1);
        check("lez_fn", {31'h0, cond_ref(3'd5, 16'h8000)}, 32'h1);

        // Condition sweep over every code and three operand values.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                step("sweep", 1'b1, 1'b0, 16'h0040 + 16'(c * 2), 3'(c), sweep_a[k],
                     1'($urandom_range(0, 1)), 16'hA000 + 16'(c * 16 + k),
                     16'h5000 + 16'(c * 16 + k), 16'h0004);
            end
        end

        // Directed sweep expectations for GTZ and LEZ, independent of the model.
        step("gtz1", 1'b1, 1'b0, 16'h0002, 3'd4, 16'h0001, 1'b0, 16'h1234, 16'h4321, 16'h0002);
        check("gtz1_direct", {31'h0, out_taken}, 32'h1);
        step("lez0", 1'b1, 1'b0, 16'h0002, 3'd5, 16'h0001, 1'b0, 16'h1234, 16'h4321, 16'h0002);
        check("lez0_direct", {31'h0, out_taken}, 32'h0);

        // Training on pc 0x10 (index 8) from a fresh table; first cycle is
        // also the same-cycle lookup/update case.
        do_reset("reset2");
        step("train1", 1'b1, 1'b0, 16'h0010, 3'd0, 16'h0000, 1'b0, 16'hBEEF, 16'h0012, 16'h0010);
        check("train1_mispred", {31'h0, out_mispred}, 32'h1);
        check("train1_redir", {16'h0, out_redirect}, 32'h0000BEEF);
        check("train1_lk", {31'h0, lk_taken}, 32'h1);
        step("train2", 1'b1, 1'b0, 16'h0010, 3'd0, 16'h0000, 1'b1, 16'hBEEF, 16'h0012, 16'h0010);
        step("train3", 1'b1, 1'b0, 16'h0010, 3'd0, 16'h0000, 1'b1, 16'hBEEF, 16'h0012, 16'h0010);
        check("train_cnt", m_cnt[8], 32'd3);

        // Flush kills the resolution: no output, no training, no stats.
        step("flush", 1'b1, 1'b1, 16'h0010, 3'd7, 16'h0000, 1'b1, 16'h1111, 16'h2222, 16'h0010);
        check("flush_redir_hold", {16'h0, out_redirect}, 32'h0000BEEF);
        step("idle", 1'b0, 1'b0, 16'h0010, 3'd7, 16'h0000, 1'b1, 16'h1111, 16'h2222, 16'h0010);

        // Randomised run; small PC range forces aliasing and saturation.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] pc;
            pc = 16'($urandom_range(0, 63)) << 1;
            step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), pc,
                 3'($urandom_range(0, 7)), pick_a[$urandom_range(0, 4)] ^ 16'($urandom_range(0, 1) * $urandom),
                 ($urandom_range(0, 3) == 0) ? ~pred_of(pc) : pred_of(pc),
                 16'($urandom), 16'($urandom), 16'($urandom_range(0, 63)) << 1);
        end

        // Five resolutions with two mispredicts, then reset mid-stream.
        do_reset("reset3");
        step("st1", 1'b1, 1'b0, 16'h0020, 3'd6, 16'h0000, 1'b0, 16'h0100, 16'h0022, 16'h0020);
        step("st2", 1'b1, 1'b0, 16'h0020, 3'd6, 16'h0000, 1'b1, 16'h0100, 16'h0022, 16'h0020);
        step("st3", 1'b1, 1'b0, 16'h0020, 3'd6, 16'h0000, 1'b1, 16'h0100, 16'h0022, 16'h0020);
        step("st4", 1'b1, 1'b0, 16'h0020, 3'd6, 16'h0000, 1'b1, 16'h0100, 16'h0022, 16'h0020);
        step("st5", 1'b1, 1'b0, 16'h0020, 3'd6, 16'h0000, 1'b0, 16'h0100, 16'h0022, 16'h0020);
`ifdef BRANCH_STATS_EN
        check("stats5_br", {16'h0, stat_br}, 32'd5);
        check("stats5_mp", {16'h0, stat_mp}, 32'd2);
`endif
        lk_pc = 16'h0020;
        res_valid = 1'b1;
        do_reset("midreset");
        check("midreset_lk", {31'h0, lk_taken}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
